// File: rtl/score_text_mux.sv
`default_nettype none
// ============================================================================
// Module      : score_text_mux
// Description : Text-overlay character buffer with a 2-stage pixel-to-glyph
//               lookup and a binary-to-BCD score writer.
// Revision    : 1.0
// ============================================================================
module score_text_mux #(
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int CODE_W     = 6,
    parameter int SCORE_W    = 14,
    parameter int DIGITS     = 4,
    parameter int SCORE_ADDR = 16,
    parameter int DIGIT_BASE = 10,
    parameter int LEAD_BLANK = 1
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic [10:0]                      offsetX,
    input  logic [10:0]                      offsetY,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [$clog2(COLS*ROWS)-1:0]     wr_addr,
    input  logic [CODE_W-1:0]                wr_code,
    input  logic [SCORE_W-1:0]               score,
    input  logic                             score_load,
    output logic                             busy,
    output logic [10:0]                      outOffsetX,
    output logic [10:0]                      outOffsetY,
    output logic [CODE_W-1:0]                letter,
    output logic                             letter_valid
);
    localparam int c_n  = COLS * ROWS;
    localparam int c_aw = $clog2(c_n);
    localparam int c_xb = $clog2(CHAR_W);
    localparam int c_yb = $clog2(CHAR_H);
    localparam int c_bw = 4 * DIGITS;
    localparam int c_cw = $clog2(SCORE_W + DIGITS + 1);

    function automatic int pow10(input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [CODE_W-1:0] init_code(input int idx);
        case (idx)
            0:       return CODE_W'(4);
            1:       return CODE_W'(6);
            2:       return CODE_W'(8);
            3:       return CODE_W'(2);
            4:       return CODE_W'(3);
            default: return '0;
        endcase
    endfunction

    localparam logic [31:0] c_score_max = 32'(pow10(DIGITS) - 1);
    localparam logic [10:0] c_cols      = 11'(COLS);
    localparam logic [10:0] c_rows      = 11'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    logic [CODE_W-1:0]  r_mem [0:c_n-1];
    state_t             r_state;
    logic [SCORE_W-1:0] r_bin;
    logic [c_bw-1:0]    r_bcd;
    logic [c_bw-1:0]    w_adj;
    logic [c_cw-1:0]    r_cnt;
    logic               r_lead;

    logic [10:0]        r_col, r_row, r_modx, r_mody;
    logic               r_in1;
    logic [c_aw-1:0]    w_cell;

    logic [3:0]         w_digit;
    logic               w_last;
    logic               w_blank;
    logic [CODE_W-1:0]  w_dcode;
    logic [31:0]        w_daddr;
    logic               w_host_wr;

    assign busy     = (r_state != S_IDLE);
    assign wr_ready = !busy;

    // Stage 1: split the pixel position into cell coordinates and glyph offsets
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_col  <= '0;
            r_row  <= '0;
            r_modx <= '0;
            r_mody <= '0;
            r_in1  <= 1'b0;
        end else begin
            r_col  <= offsetX >> c_xb;
            r_row  <= offsetY >> c_yb;
            r_modx <= offsetX & 11'(CHAR_W - 1);
            r_mody <= offsetY & 11'(CHAR_H - 1);
            r_in1  <= ((offsetX >> c_xb) < c_cols) && ((offsetY >> c_yb) < c_rows);
        end
    end

    assign w_cell = c_aw'(r_row * c_cols + r_col);

    // Stage 2: buffer read happens on the same edge as any write, so a
    // colliding write is seen by the following read only.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            letter       <= '0;
            letter_valid <= 1'b0;
            outOffsetX   <= '0;
            outOffsetY   <= '0;
        end else begin
            letter       <= r_in1 ? r_mem[w_cell] : '0;
            letter_valid <= r_in1;
            outOffsetX   <= r_modx;
            outOffsetY   <= r_mody;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                            : r_bcd[4*g +: 4];
    end

    assign w_digit   = r_bcd[c_bw-1 -: 4];
    assign w_last    = (r_cnt == c_cw'(DIGITS - 1));
    assign w_blank   = (LEAD_BLANK != 0) && r_lead && (w_digit == 4'd0) && !w_last;
    assign w_dcode   = w_blank ? '0 : CODE_W'(DIGIT_BASE) + CODE_W'(w_digit);
    assign w_daddr   = 32'(SCORE_ADDR) + 32'(r_cnt);
    assign w_host_wr = wr_valid && (r_state == S_IDLE) && (32'(wr_addr) < 32'(c_n));

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_lead  <= 1'b0;
            for (int i = 0; i < c_n; i++) r_mem[i] <= init_code(i);
        end else begin
            if (w_host_wr) r_mem[wr_addr] <= wr_code;
            case (r_state)
                S_IDLE: begin
                    if (score_load) begin
                        r_bin   <= (32'(score) > c_score_max) ? SCORE_W'(c_score_max) : score;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd <= (w_adj << 1) | {{(c_bw-1){1'b0}}, r_bin[SCORE_W-1]};
                    r_bin <= r_bin << 1;
                    if (r_cnt == c_cw'(SCORE_W - 1)) begin
                        r_cnt   <= '0;
                        r_lead  <= 1'b1;
                        r_state <= S_WRITE;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                S_WRITE: begin
                    if (w_daddr < 32'(c_n)) r_mem[w_daddr[c_aw-1:0]] <= w_dcode;
                    if (!w_blank) r_lead <= 1'b0;
                    r_bcd <= r_bcd << 4;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_score_text_mux.sv
`default_nettype none
// Testbench for score_text_mux: randomized lookups and score conversions
// checked against an arithmetic model of the character buffer.
module tb_score_text_mux;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic [10:0] offsetX, offsetY;
    logic        wr_valid, wr_ready;
    logic [4:0]  wr_addr;
    logic [5:0]  wr_code;
    logic [13:0] score;
    logic        score_load, busy;
    logic [10:0] outOffsetX, outOffsetY;
    logic [5:0]  letter;
    logic        letter_valid;

    logic        wr2_valid, wr2_ready, busy2;
    logic [5:0]  wr2_addr, wr2_code;
    logic [10:0] out2X, out2Y;
    logic [5:0]  letter2;
    logic        letter2_valid;

    int total = 0;
    int bad   = 0;
    int model  [32];
    int model2 [40];

    score_text_mux dut (
        .clk(clk), .resetN(resetN), .offsetX(offsetX), .offsetY(offsetY),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_code(wr_code),
        .score(score), .score_load(score_load), .busy(busy),
        .outOffsetX(outOffsetX), .outOffsetY(outOffsetY),
        .letter(letter), .letter_valid(letter_valid)
    );

    // 20x2 grid so that address 40 is representable yet outside the buffer
    score_text_mux #(.COLS(20)) dut2 (
        .clk(clk), .resetN(resetN), .offsetX(offsetX), .offsetY(offsetY),
        .wr_valid(wr2_valid), .wr_ready(wr2_ready), .wr_addr(wr2_addr), .wr_code(wr2_code),
        .score(14'd0), .score_load(1'b0), .busy(busy2),
        .outOffsetX(out2X), .outOffsetY(out2Y),
        .letter(letter2), .letter_valid(letter2_valid)
    );

    task automatic model_reset;
        for (int i = 0; i < 32; i++) model[i] = 0;
        for (int i = 0; i < 40; i++) model2[i] = 0;
        model[0] = 4; model[1] = 6; model[2] = 8; model[3] = 2; model[4] = 3;
        model2[0] = 4; model2[1] = 6; model2[2] = 8; model2[3] = 2; model2[4] = 3;
    endtask

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    // Code for score digit i (0 = most significant) under leading blanking
    function automatic int digit_code(input int s, input int i);
        int v = (s > 9999) ? 9999 : s;
        int w = pow10(3 - i);
        if (i < 3 && v < w) return 0;
        return 10 + (v / w) % 10;
    endfunction

    task automatic read_px(input int x, input int y);
        offsetX = 11'(x);
        offsetY = 11'(y);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic read_cell(input int idx);
        read_px((idx % 16) * 8 + $urandom_range(7, 0), (idx / 16) * 16 + $urandom_range(15, 0));
    endtask

    task automatic run_score(input int s, output int cycles);
        score = 14'(s);
        score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) model[16 + i] = digit_code(s, i);
    endtask

    task automatic test_reset;
        resetN = 1'b0; wr_valid = 1'b0; wr2_valid = 1'b0; score_load = 1'b0;
        wr_addr = '0; wr_code = '0; wr2_addr = '0; wr2_code = '0; score = '0;
        offsetX = 11'd17; offsetY = 11'd3;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, wr_ready, letter, letter_valid, outOffsetX, outOffsetY} !==
            {1'b0, 1'b1, 6'd0, 1'b0, 11'd0, 11'd0}) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0b ready=%0b letter=%0d valid=%0b ox=%0d oy=%0d, want 0 1 0 0 0 0",
                     busy, wr_ready, letter, letter_valid, outOffsetX, outOffsetY);
        end
        resetN = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            read_cell(c);
            total++;
            if (int'(letter) !== model[c]) begin
                bad++;
                $display("FAIL reset_cell%0d: got %0d want %0d", c, letter, model[c]);
            end
        end
    endtask

    task automatic test_fixed_lookup;
        read_px(17, 3);
        total++;
        if ({letter, letter_valid, outOffsetX, outOffsetY} !== {6'd8, 1'b1, 11'd1, 11'd3}) begin
            bad++;
            $display("FAIL lookup_17_3: got l=%0d v=%0b ox=%0d oy=%0d want 8 1 1 3",
                     letter, letter_valid, outOffsetX, outOffsetY);
        end
        read_px(130, 0);
        total++;
        if ({letter, letter_valid, outOffsetX, outOffsetY} !== {6'd0, 1'b0, 11'd2, 11'd0}) begin
            bad++;
            $display("FAIL lookup_col16: got l=%0d v=%0b ox=%0d oy=%0d want 0 0 2 0",
                     letter, letter_valid, outOffsetX, outOffsetY);
        end
    endtask

    task automatic test_read_before_write;
        offsetX = 11'd11; offsetY = 11'd2;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 5'd1; wr_code = 6'd33;
        @(negedge clk);
        wr_valid = 1'b0;
        total++;
        if (letter !== 6'd6) begin
            bad++;
            $display("FAIL rbw_old: got %0d want 6", letter);
        end
        model[1] = 33;
        @(negedge clk);
        total++;
        if (letter !== 6'd33) begin
            bad++;
            $display("FAIL rbw_new: got %0d want 33", letter);
        end
    endtask

    task automatic test_random_lookup;
        int xs[$];
        int ys[$];
        for (int k = 0; k <= 150; k++) begin
            if (k < 150) begin
                xs.push_back($urandom_range(200, 0));
                ys.push_back($urandom_range(47, 0));
                offsetX = 11'(xs[k]);
                offsetY = 11'(ys[k]);
            end
            @(negedge clk);
            if (k >= 1) begin
                int x = xs[k-1];
                int y = ys[k-1];
                logic v = (x / 8 < 16) && (y / 16 < 2);
                int l = v ? model[(y / 16) * 16 + x / 8] : 0;
                total++;
                if ({letter, letter_valid, outOffsetX, outOffsetY} !==
                    {6'(l), v, 11'(x % 8), 11'(y % 16)}) begin
                    bad++;
                    $display("FAIL rand_px(%0d,%0d): got l=%0d v=%0b ox=%0d oy=%0d want %0d %0b %0d %0d",
                             x, y, letter, letter_valid, outOffsetX, outOffsetY, l, v, x % 8, y % 16);
                end
            end
        end
    endtask

    task automatic test_host_write;
        for (int k = 0; k < 20; k++) begin
            int a = $urandom_range(31, 0);
            int c = $urandom_range(63, 0);
            wr_valid = 1'b1; wr_addr = 5'(a); wr_code = 6'(c);
            total++;
            if (wr_ready !== 1'b1) begin
                bad++;
                $display("FAIL wr_ready_idle: got %0b want 1", wr_ready);
            end
            @(negedge clk);
            model[a] = c;
        end
        wr_valid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            read_cell(c);
            total++;
            if (int'(letter) !== model[c]) begin
                bad++;
                $display("FAIL host_cell%0d: got %0d want %0d", c, letter, model[c]);
            end
        end
    endtask

    task automatic test_score;
        int scores[$] = '{1234, 7, 12000, 0, 9999, 100, 16383};
        int cyc;
        for (int k = 0; k < 3; k++) scores.push_back($urandom_range(16383, 0));
        foreach (scores[n]) begin
            run_score(scores[n], cyc);
            total++;
            if (cyc !== 18) begin
                bad++;
                $display("FAIL busy_len score=%0d: got %0d want 18", scores[n], cyc);
            end
            for (int i = 0; i < 4; i++) begin
                read_cell(16 + i);
                total++;
                if (int'(letter) !== model[16 + i]) begin
                    bad++;
                    $display("FAIL score%0d_cell%0d: got %0d want %0d", scores[n], 16 + i, letter, model[16 + i]);
                end
            end
        end
    endtask

    task automatic test_busy_block;
        int cyc = 0;
        score = 14'd4321; score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
        total++;
        if ({busy, wr_ready} !== 2'b10) begin
            bad++;
            $display("FAIL busy_ready: got busy=%0b ready=%0b want 1 0", busy, wr_ready);
        end
        wr_valid = 1'b1; wr_addr = 5'd0; wr_code = 6'd63;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        score = 14'd55; score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL load_not_queued: got busy=%0b want 0", busy);
        end
        for (int i = 0; i < 4; i++) model[16 + i] = digit_code(4321, i);
        read_cell(0);
        total++;
        if (int'(letter) !== model[0]) begin
            bad++;
            $display("FAIL busy_write_dropped: got %0d want %0d", letter, model[0]);
        end
        for (int i = 0; i < 4; i++) begin
            read_cell(16 + i);
            total++;
            if (int'(letter) !== model[16 + i]) begin
                bad++;
                $display("FAIL busy_cell%0d: got %0d want %0d", 16 + i, letter, model[16 + i]);
            end
        end
    endtask

    task automatic test_addr_oob;
        int cells[$] = '{0, 1, 2, 3, 4, 8, 39};
        wr2_valid = 1'b1; wr2_addr = 6'd40; wr2_code = 6'd5;
        total++;
        if (wr2_ready !== 1'b1) begin
            bad++;
            $display("FAIL oob_ready: got %0b want 1", wr2_ready);
        end
        @(negedge clk);
        wr2_addr = 6'd39; wr2_code = 6'd21;
        @(negedge clk);
        wr2_valid = 1'b0;
        model2[39] = 21;
        foreach (cells[n]) begin
            int c = cells[n];
            read_px((c % 20) * 8 + 5, (c / 20) * 16 + 9);
            total++;
            if ({letter2, letter2_valid} !== {6'(model2[c]), 1'b1}) begin
                bad++;
                $display("FAIL oob_cell%0d: got %0d/%0b want %0d/1", c, letter2, letter2_valid, model2[c]);
            end
        end
    endtask

    task automatic test_reset_mid_conv;
        score = 14'd1234; score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midconv_busy: got %0b want 1", busy);
        end
        resetN = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midconv_abort: got busy=%0b want 0", busy);
        end
        resetN = 1'b1;
        model_reset();
        repeat (20) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            if (c < 5 || c >= 16) begin
                read_cell(c);
                total++;
                if (int'(letter) !== model[c]) begin
                    bad++;
                    $display("FAIL midconv_cell%0d: got %0d want %0d", c, letter, model[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_lookup();
        test_read_before_write();
        test_random_lookup();
        test_host_write();
        test_score();
        test_busy_block();
        test_addr_oob();
        test_reset_mid_conv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
